// File: rtl/pll_nco_clkgen.sv
`default_nettype none
// ============================================================================
// pll_nco_clkgen : NCO-based programmable clock-enable generator with lock FSM
// Revision: 1.0
// ============================================================================
module pll_nco_clkgen #(
  parameter int          NUM_CLOCKS   = 2,
  parameter int          ACC_WIDTH    = 24,
  parameter int          LOCK_CYCLES  = 16,
  parameter int unsigned DEFAULT_INCR = 0,
  parameter int          CHAN_W       = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CHAN_W-1:0]     cfg_chan,
  input  logic [ACC_WIDTH-1:0]  cfg_incr,
  input  logic [ACC_WIDTH-1:0]  cfg_phase,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk_en,
  output logic [NUM_CLOCKS-1:0] outclk_phase,
  output logic                  locked
);

  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [1:0] c_st_settle = 2'd0;
  localparam logic [1:0] c_st_locked = 2'd1;
  localparam logic [1:0] c_st_apply  = 2'd2;

  localparam logic [CNT_W-1:0]     c_cnt_last     = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [ACC_WIDTH-1:0] c_default_incr = ACC_WIDTH'(DEFAULT_INCR);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             w_locked;
  logic             w_accept;
  logic             w_chan_bad;

  assign w_locked   = (r_state == c_st_locked);
  assign w_accept   = cfg_valid & w_locked;
  assign w_chan_bad = (32'(cfg_chan) >= 32'(NUM_CLOCKS));

  assign locked    = w_locked;
  assign cfg_ready = w_locked;
  assign cfg_err   = r_err;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state <= c_st_settle;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept & w_chan_bad;
      case (r_state)
        c_st_settle: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == c_cnt_last) begin
            r_state <= c_st_locked;
          end
        end
        c_st_locked: begin
          if (w_accept && !w_chan_bad) begin
            r_state <= c_st_apply;
          end
        end
        c_st_apply: begin
          r_cnt   <= '0;
          r_state <= c_st_settle;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= c_st_settle;
        end
      endcase
    end
  end

  // One NCO per channel; APPLY reloads every accumulator at once to align phases.
  for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_incr;
    logic [ACC_WIDTH-1:0] r_phase;
    logic                 r_en;
    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_wr;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_incr};
    assign w_wr  = w_accept & ~w_chan_bad & (cfg_chan == CHAN_W'(i));

    always_ff @(posedge refclk) begin
      if (rst) begin
        r_acc   <= '0;
        r_incr  <= c_default_incr;
        r_phase <= '0;
        r_en    <= 1'b0;
      end else begin
        if (r_state == c_st_apply) begin
          r_acc <= r_phase;
          r_en  <= 1'b0;
        end else begin
          r_acc <= w_sum[ACC_WIDTH-1:0];
          r_en  <= w_sum[ACC_WIDTH] & w_locked;
        end
        if (w_wr) begin
          r_incr  <= cfg_incr;
          r_phase <= cfg_phase;
        end
      end
    end

    assign outclk_en[i]    = r_en;
    assign outclk_phase[i] = r_acc[ACC_WIDTH-1];
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_nco_clkgen.sv
`default_nettype none
// ============================================================================
// tb_pll_nco_clkgen : self-checking bench against an arithmetic NCO model
// Revision: 1.0
// ============================================================================
module tb_pll_nco_clkgen;

  localparam int N    = 3;
  localparam int W    = 8;
  localparam int LOCK = 16;
  localparam int DEF  = 64;
  localparam int P    = 256;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_chan = '0;
  logic [7:0] cfg_incr = '0;
  logic [7:0] cfg_phase = '0;
  logic       cfg_err;
  logic [2:0] outclk_en;
  logic [2:0] outclk_phase;
  logic       locked;

  pll_nco_clkgen #(
    .NUM_CLOCKS  (N),
    .ACC_WIDTH   (W),
    .LOCK_CYCLES (LOCK),
    .DEFAULT_INCR(DEF)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_chan    (cfg_chan),
    .cfg_incr    (cfg_incr),
    .cfg_phase   (cfg_phase),
    .cfg_err     (cfg_err),
    .outclk_en   (outclk_en),
    .outclk_phase(outclk_phase),
    .locked      (locked)
  );

  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Behavioural model: plain modular arithmetic plus a countdown to lock.
  int m_acc[N];
  int m_incr[N];
  int m_phase[N];
  bit m_en[N];
  bit m_err;
  bit m_apply;
  int m_wait;
  bit m_lk;
  int m_ch;

  always @(posedge refclk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_acc[i] = 0; m_incr[i] = DEF; m_phase[i] = 0; m_en[i] = 0;
      end
      m_err = 0; m_apply = 0; m_wait = LOCK;
    end else if (m_apply) begin
      for (int i = 0; i < N; i++) begin
        m_acc[i] = m_phase[i]; m_en[i] = 0;
      end
      m_err = 0; m_apply = 0; m_wait = LOCK;
    end else begin
      m_lk = (m_wait == 0);
      for (int i = 0; i < N; i++) begin
        m_en[i]  = m_lk && (m_acc[i] + m_incr[i] >= P);
        m_acc[i] = (m_acc[i] + m_incr[i]) % P;
      end
      m_err = 0;
      if (!m_lk) begin
        m_wait = m_wait - 1;
      end else if (cfg_valid) begin
        m_ch = int'(cfg_chan);
        if (m_ch < N) begin
          m_incr[m_ch]  = int'(cfg_incr);
          m_phase[m_ch] = int'(cfg_phase);
          m_apply = 1;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  logic [2:0] e_en;
  logic [2:0] e_ph;
  logic       e_lk;

  always @(negedge refclk) begin
    if (chk_on) begin
      for (int i = 0; i < N; i++) begin
        e_en[i] = m_en[i];
        e_ph[i] = (m_acc[i] >= P / 2);
      end
      e_lk = (m_wait == 0) && !m_apply;
      chk("locked", 32'(locked), 32'(e_lk));
      chk("cfg_ready", 32'(cfg_ready), 32'(e_lk));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      chk("outclk_en", 32'(outclk_en), 32'(e_en));
      chk("outclk_phase", 32'(outclk_phase), 32'(e_ph));
    end
  end

  task automatic cfg_write(input int ch, input int inc, input int ph);
    bit ok;
    ok = 0;
    cfg_chan  = 2'(ch);
    cfg_incr  = 8'(inc);
    cfg_phase = 8'(ph);
    cfg_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge refclk);
      if (cfg_ready === 1'b1 && rst === 1'b0) begin
        @(posedge refclk);
        #2;
        ok = 1;
        break;
      end
    end
    cfg_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL cfg_accept: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic wait_lock();
    bit ok;
    ok = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge refclk);
      if (locked === 1'b1) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_lock: got locked=0 expected locked=1 within 60 cycles");
    end
  endtask

  // Pulses rst for one edge, checks reset values, then measures edges to lock.
  task automatic reset_and_lock(input string nm);
    int n;
    int pulses;
    rst = 1'b1;
    @(posedge refclk);
    #2 rst = 1'b0;
    @(negedge refclk);
    chk({nm, "_rst_locked"}, 32'(locked), 32'd0);
    chk({nm, "_rst_ready"}, 32'(cfg_ready), 32'd0);
    chk({nm, "_rst_en"}, 32'(outclk_en), 32'd0);
    chk({nm, "_rst_phase"}, 32'(outclk_phase), 32'd0);
    chk({nm, "_rst_err"}, 32'(cfg_err), 32'd0);
    n = 1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge refclk);
      pulses += int'(outclk_en != 0);
      if (locked === 1'b1) break;
      n++;
    end
    chk({nm, "_lock_edge"}, 32'(n), 32'd16);
    chk({nm, "_pre_lock_pulses"}, 32'(pulses), 32'd0);
  endtask

  task automatic count_pulses(input int ncyc, output int c0, output int c1, output int c2,
                              output int ph0_hi);
    c0 = 0; c1 = 0; c2 = 0; ph0_hi = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge refclk);
      c0 += int'(outclk_en[0]);
      c1 += int'(outclk_en[1]);
      c2 += int'(outclk_en[2]);
      ph0_hi += int'(outclk_phase[0]);
    end
  endtask

  int c0, c1, c2, ph;
  int f0, f1;
  int idle;

  initial begin
    rst = 1'b1;
    @(posedge refclk);
    #1 chk_on = 1'b1;

    // Reset and lock latency
    reset_and_lock("init");
    count_pulses(64, c0, c1, c2, ph);
    chk("init_ch0_rate", 32'(c0), 32'd16);
    chk("init_ch1_rate", 32'(c1), 32'd16);

    // Frequency program: ch0 -> 3 pulses per 4 cycles
    cfg_write(0, 192, 0);
    wait_lock();
    count_pulses(64, c0, c1, c2, ph);
    chk("freq_ch0", 32'(c0), 32'd48);
    chk("freq_ch1", 32'(c1), 32'd16);

    // Invalid channel: error pulse, lock undisturbed
    cfg_write(3, 17, 33);
    @(negedge refclk);
    chk("inv_err_hi", 32'(cfg_err), 32'd1);
    chk("inv_locked", 32'(locked), 32'd1);
    @(negedge refclk);
    chk("inv_err_lo", 32'(cfg_err), 32'd0);

    // Phase offset: ch1 leads ch0 by two cycles
    cfg_write(0, 64, 0);
    wait_lock();
    cfg_write(1, 64, 128);
    wait_lock();
    f0 = -1; f1 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge refclk);
      if (outclk_en[0] && f0 < 0) f0 = k;
      if (outclk_en[1] && f1 < 0) f1 = k;
    end
    chk("phase_first_ch1", 32'(f1), 32'd2);
    chk("phase_lead", 32'(f0 - f1), 32'd2);

    // Max increment: 255 pulses per 256 cycles
    cfg_write(0, 255, 0);
    wait_lock();
    count_pulses(256, c0, c1, c2, ph);
    chk("max_ch0", 32'(c0), 32'd255);
    chk("max_ch1", 32'(c1), 32'd64);

    // Disabled channel: no pulses, phase constant low
    cfg_write(0, 0, 0);
    wait_lock();
    count_pulses(1000, c0, c1, c2, ph);
    chk("zero_ch0", 32'(c0), 32'd0);
    chk("zero_ph0", 32'(ph), 32'd0);
    chk("zero_ch2", 32'(c2), 32'd250);

    // Reset during SETTLE with a config request held across it
    cfg_write(0, 192, 0);
    repeat (3) @(posedge refclk);
    #2;
    cfg_chan  = 2'd1;
    cfg_incr  = 8'd128;
    cfg_phase = 8'd0;
    cfg_valid = 1'b1;
    reset_and_lock("mid");
    @(posedge refclk);
    #2 cfg_valid = 1'b0;
    wait_lock();
    count_pulses(64, c0, c1, c2, ph);
    chk("mid_ch0_default", 32'(c0), 32'd16);
    chk("mid_ch1_new", 32'(c1), 32'd32);
    chk("mid_ch2_default", 32'(c2), 32'd16);

    // Randomized configuration traffic with occasional resets
    for (int it = 0; it < 40; it++) begin
      cfg_write($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
      idle = $urandom_range(0, 30);
      repeat (idle) @(posedge refclk);
      #2;
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        @(posedge refclk);
        #2 rst = 1'b0;
      end
    end
    repeat (40) @(posedge refclk);
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
